// File: rtl/fu_register_file.sv
// rtl/fu_register_file.sv - two-read/one-write register file with V/C/N/Z status register
module fu_register_file #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          R0_ZERO = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  output logic [3:0]        flags_out
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;

  logic wr_is_r0;
  logic wr_fire;
  logic byp_a;
  logic byp_b;
  logic rd_a_is_r0;
  logic rd_b_is_r0;

  // Decode whether the write targets a storable register and which read ports it forwards to
  always_comb begin
    wr_is_r0   = R0_ZERO && (wr_addr == '0);
    wr_fire    = wr_en && !wr_is_r0;
    rd_a_is_r0 = R0_ZERO && (rd_addr_a == '0);
    rd_b_is_r0 = R0_ZERO && (rd_addr_b == '0);
    byp_a      = BYPASS && wr_fire && !rst && (wr_addr == rd_addr_a);
    byp_b      = BYPASS && wr_fire && !rst && (wr_addr == rd_addr_b);
  end

  // Register array: cleared asynchronously, one write per rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Status register next state: load on flag_we, otherwise hold
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = flags_in;
    end
  end

  // Status register: cleared asynchronously, loaded independently of the data write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Read port A: hardwired zero beats bypass, bypass beats stored value
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (rd_a_is_r0) begin
      rd_data_a = '0;
    end else if (byp_a) begin
      rd_data_a = wr_data;
    end
  end

  // Read port B: same priority as port A so both agree on a shared address
  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (rd_b_is_r0) begin
      rd_data_b = '0;
    end else if (byp_b) begin
      rd_data_b = wr_data;
    end
  end

  assign flags_out = flags_q;

endmodule

// File: tb/tb_fu_register_file.sv
// tb/tb_fu_register_file.sv - directed scoreboard bench for fu_register_file
module tb_fu_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        flag_we;
  logic [3:0]  flags_in;

  logic [31:0] m_rd_a, m_rd_b, x_rd_a, x_rd_b;
  logic [3:0]  m_flags, x_flags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb [$];

  always #5 clk = ~clk;

  // main instance: R0_ZERO=1, BYPASS=1
  fu_register_file #(.WIDTH(32), .ADDR_W(5), .R0_ZERO(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(m_rd_a), .rd_data_b(m_rd_b),
    .flag_we(flag_we), .flags_in(flags_in), .flags_out(m_flags)
  );

  // alternate instance: R0_ZERO=0, BYPASS=0
  fu_register_file #(.WIDTH(32), .ADDR_W(5), .R0_ZERO(1'b0), .BYPASS(1'b0)) dut_alt (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(x_rd_a), .rd_data_b(x_rd_b),
    .flag_we(flag_we), .flags_in(flags_in), .flags_out(x_flags)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return m_rd_a;
      1: return m_rd_b;
      2: return {28'd0, m_flags};
      3: return x_rd_a;
      4: return x_rd_b;
      default: return {28'd0, x_flags};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mm [32];
    logic [31:0] mx [32];
    logic [31:0] v;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = 5'd5; rd_addr_b = 5'd0; flag_we = 1'b0; flags_in = '0;
    #2;
    push("reset_rd_a", 0, 32'h0); push("reset_flags", 2, 32'h0);
    push("reset_alt_rd_a", 3, 32'h0); push("reset_alt_flags", 5, 32'h0);
    drain();
    tick();
    rst = 1'b0;

    // 1: load reg5 and flags, then asynchronous reset mid-cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; flag_we = 1'b1; flags_in = 4'b1010;
    tick();
    wr_en = 1'b0; flag_we = 1'b0; rd_addr_a = 5'd5;
    #2;
    push("t1_loaded_reg5", 0, 32'hDEADBEEF); push("t1_loaded_flags", 2, 32'hA);
    push("t1_alt_loaded_flags", 5, 32'hA);
    drain();
    rst = 1'b1;
    #1;
    push("t1_async_rd_a", 0, 32'h0); push("t1_async_flags", 2, 32'h0);
    push("t1_alt_async_rd_a", 3, 32'h0); push("t1_alt_async_flags", 5, 32'h0);
    drain();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000055; flag_we = 1'b1; flags_in = 4'b1111;
    #1;
    push("t1_rst_no_bypass", 0, 32'h0);
    drain();
    tick();
    push("t1_rst_blocks_write", 0, 32'h0); push("t1_rst_blocks_flags", 2, 32'h0);
    push("t1_alt_rst_blocks_write", 3, 32'h0);
    drain();
    wr_en = 1'b0; flag_we = 1'b0; flags_in = '0;
    rst = 1'b0;
    tick();

    // 2: write reg3, read it on both ports
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    #2;
    push("t2_rd_a", 0, 32'h12345678); push("t2_rd_b", 1, 32'h12345678);
    push("t2_alt_rd_a", 3, 32'h12345678); push("t2_alt_rd_b", 4, 32'h12345678);
    drain();

    // X on wr_addr with wr_en low must leave reg3 intact
    wr_addr = 'x; wr_data = 32'hCAFEF00D;
    tick();
    push("x_addr_no_effect", 0, 32'h12345678); push("x_addr_alt_no_effect", 3, 32'h12345678);
    drain();

    // 3: bypass vs. no bypass on reg7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000001;
    tick();
    wr_data = 32'hAAAA5555; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #2;
    push("t3_bypass_a", 0, 32'hAAAA5555); push("t3_bypass_b", 1, 32'hAAAA5555);
    push("t3_alt_old_a", 3, 32'h00000001); push("t3_alt_old_b", 4, 32'h00000001);
    drain();
    tick();
    wr_en = 1'b0;
    #2;
    push("t3_after_a", 0, 32'hAAAA5555); push("t3_alt_after_a", 3, 32'hAAAA5555);
    drain();

    // 4: writes to reg0
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr_b = 5'd0;
    #2;
    push("t4_r0_write_cycle", 1, 32'h0); push("t4_alt_r0_write_cycle", 4, 32'h0);
    drain();
    tick();
    wr_en = 1'b0;
    #2;
    push("t4_r0_after", 1, 32'h0); push("t4_alt_r0_after", 4, 32'hFFFFFFFF);
    drain();

    // 5: flag load together with a data write, then flags hold
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h80000000; flag_we = 1'b1; flags_in = 4'b0101;
    #2;
    push("t5_flags_no_bypass", 2, 32'h0);
    drain();
    tick();
    wr_en = 1'b0; flag_we = 1'b0; flags_in = 4'b1111; rd_addr_a = 5'd9;
    #2;
    push("t5_flags_loaded", 2, 32'h5); push("t5_reg9", 0, 32'h80000000);
    push("t5_alt_flags_loaded", 5, 32'h5); push("t5_alt_reg9", 3, 32'h80000000);
    drain();
    tick();
    push("t5_flags_hold", 2, 32'h5); push("t5_alt_flags_hold", 5, 32'h5);
    drain();

    // 6: sweep every register, then read mirrored pairs
    for (int i = 0; i < 32; i++) begin
      mm[i] = 32'h0;
      mx[i] = 32'h0;
    end
    mx[0] = 32'hFFFFFFFF;
    for (int i = 1; i < 32; i++) begin
      v = i * 32'h01010101;
      wr_en = 1'b1; wr_addr = i[4:0]; wr_data = v;
      mm[i] = v;
      mx[i] = v;
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = i[4:0];
      rd_addr_b = 5'(31 - i);
      push($sformatf("t6_a_%0d", i), 0, mm[i]);
      push($sformatf("t6_b_%0d", 31 - i), 1, mm[31 - i]);
      push($sformatf("t6_alt_a_%0d", i), 3, mx[i]);
      push($sformatf("t6_alt_b_%0d", 31 - i), 4, mx[31 - i]);
      #1;
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
